// File: rtl/AluCtrlSig_pkg.sv
// Shared opcode constants, driver state encoding and opcode legality check
// for the instruction stimulus driver.
package AluCtrlSig_pkg;

  localparam logic [5:0] ADD_op  = 6'h00;
  localparam logic [5:0] J_op    = 6'h02;
  localparam logic [5:0] BEQ_op  = 6'h04;
  localparam logic [5:0] BNE_op  = 6'h05;
  localparam logic [5:0] ADDI_op = 6'h08;
  localparam logic [5:0] LW_op   = 6'h23;
  localparam logic [5:0] SW_op   = 6'h2B;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StGap,
    StDone
  } drv_state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      ADD_op, J_op, BEQ_op, BNE_op, ADDI_op, LW_op, SW_op: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/inst_prog_mem.sv
// Program store: synchronous write, combinational read. Contents are not reset.
module inst_prog_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_driver.sv
// Issuing end of the inst/pcEn/OpDone handshake: replays a loaded program one
// instruction at a time and tallies pass, fail (timeout) and skip (illegal opcode).
module inst_driver
  import AluCtrlSig_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned GAP     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [31:0]              load_data,
  output logic                     load_ready,
  input  logic                     start,
  output logic [31:0]              inst,
  output logic                     pcEn,
  input  logic                     OpDone,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               pass_cnt,
  output logic [7:0]               fail_cnt,
  output logic [7:0]               skip_cnt,
  output logic [$clog2(DEPTH):0]   prog_len
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  drv_state_e    state_q, state_d;
  logic [LW-1:0] prog_len_q, prog_len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    timer_q, timer_d;
  logic [7:0]    gap_q, gap_d;
  logic [7:0]    pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
  logic [31:0]   inst_q, inst_d;
  logic          pcen_q, pcen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic          last;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  inst_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_len_q[AW-1:0]),
    .wdata (load_data),
    .raddr (idx_q),
    .rdata (mem_rdata)
  );

  assign last = ({1'b0, idx_q} == prog_len_q - LW'(1));

  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    skip_d     = skip_q;
    inst_d     = 32'h0;
    pcen_d     = 1'b0;
    mem_we     = 1'b0;
    // done is a registered copy of the DONE state, so it lands one cycle later
    done_d     = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (load_valid && ready_q) begin
          mem_we     = 1'b1;
          prog_len_d = prog_len_q + LW'(1);
        end
        if (start) begin
          if (prog_len_q == '0) begin
            state_d = StDone;
          end else begin
            pass_d  = 8'h0;
            fail_d  = 8'h0;
            skip_d  = 8'h0;
            idx_d   = '0;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (is_legal_op(mem_rdata[31:26])) begin
          state_d = StIssue;
        end else begin
          skip_d = sat_inc(skip_q);
          if (last) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      StIssue: begin
        inst_d  = mem_rdata;
        pcen_d  = 1'b1;
        timer_d = 8'h0;
        state_d = StWait;
      end
      StWait: begin
        inst_d  = inst_q;
        pcen_d  = 1'b1;
        timer_d = timer_q + 8'd1;
        // A pass wins over a timeout expiring in the same cycle
        if (OpDone) begin
          pass_d = sat_inc(pass_q);
        end else if (timer_q == 8'(TIMEOUT)) begin
          fail_d = sat_inc(fail_q);
        end
        if (OpDone || (timer_q == 8'(TIMEOUT))) begin
          inst_d  = 32'h0;
          pcen_d  = 1'b0;
          gap_d   = 8'h0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == 8'(GAP - 1)) begin
          if (last) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = StFetch;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle) && (prog_len_d < LW'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      prog_len_q <= '0;
      idx_q      <= '0;
      timer_q    <= 8'h0;
      gap_q      <= 8'h0;
      pass_q     <= 8'h0;
      fail_q     <= 8'h0;
      skip_q     <= 8'h0;
      inst_q     <= 32'h0;
      pcen_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      skip_q     <= skip_d;
      inst_q     <= inst_d;
      pcen_q     <= pcen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign load_ready = ready_q;
  assign inst       = inst_q;
  assign pcEn       = pcen_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign skip_cnt   = skip_q;
  assign prog_len   = prog_len_q;

endmodule
